mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage.sv | 207 ++++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// Memory / write-back pipeline stage: issues one dcache access per instruction,
// shapes load data, selects the write-back value and owns a small bank of CSRs.
module mem_wb_stage #(
  parameter int          CSR_COUNT = 1,
  parameter logic [11:0] CSR_BASE  = 12'h51E,
  parameter int          MAX_WAIT  = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_inst,
  input  logic [31:0]             in_pc,
  input  logic [31:0]             in_alu,
  input  logic [31:0]             in_store_data,
  input  logic [31:0]             in_rs1,
  output logic                    out_valid,
  output logic                    out_wb_en,
  output logic [4:0]              out_rd,
  output logic [31:0]             out_wb_data,
  output logic                    out_misalign,
  output logic                    out_timeout,
  output logic [32*CSR_COUNT-1:0] csr_out,
  output logic                    dcache_req_valid,
  input  logic                    dcache_req_ready,
  output logic [31:0]             dcache_addr,
  output logic [3:0]              dcache_we,
  output logic                    dcache_re,
  output logic [31:0]             dcache_din,
  input  logic                    dcache_resp_valid,
  input  logic [31:0]             dcache_dout
);
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_SYSTEM = 7'b1110011;
  localparam logic [6:0]  OP_OP     = 7'b0110011;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [7:0]  WAIT_LAST = 8'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state_reg, state_next;

  logic [31:0] inst_reg, rs1_reg;
  logic [1:0]  addr_lo_reg;
  logic [7:0]  wait_cnt_reg;
  logic [31:0] out_wb_data_reg, dcache_addr_reg, dcache_din_reg;
  logic        out_wb_en_reg, out_misalign_reg, out_timeout_reg, dcache_re_reg;
  logic [3:0]  dcache_we_reg;

  // Decode of the instruction being offered, used only at the acceptance edge.
  logic [6:0]  acc_op;
  logic [2:0]  acc_f3;
  logic        acc_load, acc_store, acc_mem, acc_misalign, acc_writes_rd, acc_csrrw, acc_wb_en;
  logic [11:0] acc_csr_off;
  logic [31:0] acc_csr_prior, acc_wb_data, acc_din;
  logic [3:0]  acc_we;

  always_comb begin
    acc_op        = in_inst[6:0];
    acc_f3        = in_inst[14:12];
    acc_load      = (acc_op == OP_LOAD);
    acc_store     = (acc_op == OP_STORE);
    acc_mem       = acc_load | acc_store;
    acc_misalign  = acc_mem && ((acc_f3[1:0] == 2'b01 && in_alu[0]) ||
                                (acc_f3[1:0] == 2'b10 && in_alu[1:0] != 2'b00));
    acc_csrrw     = (acc_op == OP_SYSTEM) && (acc_f3[1:0] == 2'b01);
    acc_writes_rd = (acc_op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_OP, OP_IMM, OP_LOAD}) ||
                    (acc_op == OP_SYSTEM && acc_f3 != 3'b000);
    // Wrapping subtraction folds both out-of-range sides into "no index matches".
    acc_csr_off   = in_inst[31:20] - CSR_BASE;
    acc_csr_prior = '0;
    for (int i = 0; i < CSR_COUNT; i++) begin
      if (acc_csr_off == 12'(i)) acc_csr_prior = csr_out[32*i +: 32];
    end
    if (acc_op == OP_JAL || acc_op == OP_JALR) acc_wb_data = in_pc + 32'd4;
    else if (acc_csrrw)                        acc_wb_data = acc_csr_prior;
    else                                       acc_wb_data = in_alu;
    acc_wb_en = acc_writes_rd && (in_inst[11:7] != 5'd0) && !acc_misalign;
    case (acc_f3[1:0])
      2'b00:   acc_we = 4'b0001 << in_alu[1:0];
      2'b01:   acc_we = 4'b0011 << in_alu[1:0];
      default: acc_we = 4'b1111;
    endcase
    acc_din = in_store_data << {in_alu[1:0], 3'b000};
  end

  logic [31:0] ld_shift, ld_data;
  always_comb begin
    ld_shift = dcache_dout >> {addr_lo_reg, 3'b000};
    case (inst_reg[14:12])
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_data = {24'b0, ld_shift[7:0]};
      3'b101:  ld_data = {16'b0, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid) state_next = (acc_mem && !acc_misalign) ? REQ : DONE;
      REQ:  if (dcache_req_ready) state_next = (inst_reg[6:0] == OP_STORE) ? DONE : WAIT;
      WAIT: if (dcache_resp_valid || wait_cnt_reg == WAIT_LAST) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst_reg         <= '0;
      rs1_reg          <= '0;
      addr_lo_reg      <= '0;
      wait_cnt_reg     <= '0;
      out_wb_data_reg  <= '0;
      out_wb_en_reg    <= 1'b0;
      out_misalign_reg <= 1'b0;
      out_timeout_reg  <= 1'b0;
      dcache_addr_reg  <= '0;
      dcache_din_reg   <= '0;
      dcache_we_reg    <= '0;
      dcache_re_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (in_valid) begin
          inst_reg    <= in_inst;
          rs1_reg     <= in_rs1;
          addr_lo_reg <= in_alu[1:0];
          if (acc_mem && !acc_misalign) begin
            dcache_addr_reg <= {in_alu[31:2], 2'b00};
            dcache_din_reg  <= acc_din;
            dcache_we_reg   <= acc_store ? acc_we : 4'b0000;
            dcache_re_reg   <= acc_load;
          end else begin
            out_wb_data_reg  <= acc_wb_data;
            out_wb_en_reg    <= acc_wb_en;
            out_misalign_reg <= acc_misalign;
          end
        end
        REQ: if (dcache_req_ready) begin
          dcache_we_reg <= '0;
          dcache_re_reg <= 1'b0;
          wait_cnt_reg  <= '0;
        end
        WAIT: begin
          // A response in the final wait cycle takes priority over the timeout.
          if (dcache_resp_valid) begin
            out_wb_data_reg <= ld_data;
            out_wb_en_reg   <= (inst_reg[11:7] != 5'd0);
          end else if (wait_cnt_reg == WAIT_LAST) begin
            out_timeout_reg <= 1'b1;
            out_wb_data_reg <= '0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        DONE: begin
          out_wb_en_reg    <= 1'b0;
          out_misalign_reg <= 1'b0;
          out_timeout_reg  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // CSR write lands on the edge leaving DONE, so DONE still shows the prior value.
  logic        done_csrrw;
  logic [11:0] done_csr_off;
  assign done_csrrw   = (state_reg == DONE) && (inst_reg[6:0] == OP_SYSTEM) && (inst_reg[13:12] == 2'b01);
  assign done_csr_off = inst_reg[31:20] - CSR_BASE;

  generate
    for (genvar gi = 0; gi < CSR_COUNT; gi++) begin : g_csr
      logic [31:0] csr_reg;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) csr_reg <= '0;
        else if (done_csrrw && done_csr_off == 12'(gi))
          csr_reg <= inst_reg[14] ? {27'b0, inst_reg[19:15]} : rs1_reg;
      end
      assign csr_out[32*gi +: 32] = csr_reg;
    end
  endgenerate

  assign in_ready         = (state_reg == IDLE);
  assign out_valid        = (state_reg == DONE);
  assign dcache_req_valid = (state_reg == REQ);
  assign out_wb_en        = out_wb_en_reg;
  assign out_rd           = inst_reg[11:7];
  assign out_wb_data      = out_wb_data_reg;
  assign out_misalign     = out_misalign_reg;
  assign out_timeout      = out_timeout_reg;
  assign dcache_addr      = dcache_addr_reg;
  assign dcache_we        = dcache_we_reg;
  assign dcache_re        = dcache_re_reg;
  assign dcache_din       = dcache_din_reg;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with hand-computed expectations (CSR_COUNT=2, MAX_WAIT=4).
module tb_mem_wb_stage;
  localparam int CSR_COUNT = 2;
  localparam int MAX_WAIT  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_inst, in_pc, in_alu, in_store_data, in_rs1;
  logic        out_valid, out_wb_en, out_misalign, out_timeout;
  logic [4:0]  out_rd;
  logic [31:0] out_wb_data;
  logic [63:0] csr_out;
  logic        dcache_req_valid, dcache_req_ready, dcache_re, dcache_resp_valid;
  logic [31:0] dcache_addr, dcache_din, dcache_dout;
  logic [3:0]  dcache_we;

  mem_wb_stage #(.CSR_COUNT(CSR_COUNT), .CSR_BASE(12'h51E), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_alu(in_alu), .in_store_data(in_store_data), .in_rs1(in_rs1),
    .out_valid(out_valid), .out_wb_en(out_wb_en), .out_rd(out_rd), .out_wb_data(out_wb_data),
    .out_misalign(out_misalign), .out_timeout(out_timeout), .csr_out(csr_out),
    .dcache_req_valid(dcache_req_valid), .dcache_req_ready(dcache_req_ready),
    .dcache_addr(dcache_addr), .dcache_we(dcache_we), .dcache_re(dcache_re), .dcache_din(dcache_din),
    .dcache_resp_valid(dcache_resp_valid), .dcache_dout(dcache_dout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] alu,
                      input logic [31:0] sd, input logic [31:0] rs1);
    @(negedge clk);
    check("in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_inst = inst; in_pc = pc; in_alu = alu; in_store_data = sd; in_rs1 = rs1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_inst = $urandom(); in_pc = $urandom(); in_alu = $urandom(); in_store_data = $urandom(); in_rs1 = $urandom();
  endtask

  // Advances to the negedge where out_valid is seen; lat counts cycles from acceptance.
  task automatic wait_valid(input int start, output int lat);
    lat = start;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 30);
    check("out_valid_seen", 64'(out_valid), 64'd1);
  endtask

  task automatic report(input string name, input int lat);
    $display("txn %-8s lat=%0d wb_en=%0b rd=%0d wb_data=%08h misalign=%0b timeout=%0b",
             name, lat, out_wb_en, out_rd, out_wb_data, out_misalign, out_timeout);
  endtask

  task automatic next_cycle_idle(input string tag);
    @(negedge clk);
    check(tag, 64'(out_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    reset = 1'b0; in_valid = 1'b0;
    in_inst = '0; in_pc = '0; in_alu = '0; in_store_data = '0; in_rs1 = '0;
    dcache_req_ready = 1'b0; dcache_resp_valid = 1'b0; dcache_dout = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_req_valid", 64'(dcache_req_valid), 64'd0);
    check("rst_wb_data", 64'(out_wb_data), 64'd0);
    check("rst_csr", csr_out, 64'd0);
    reset = 1'b1;

    // ADDI x6: non-memory, one-cycle latency
    send(32'h00000313, 32'h100, 32'h12345678, 32'h0, 32'h0);
    wait_valid(0, lat);
    report("addi", lat);
    check("addi_lat", 64'(lat), 64'd1);
    check("addi_wb_data", 64'(out_wb_data), 64'h12345678);
    check("addi_wb_en", 64'(out_wb_en), 64'd1);
    check("addi_rd", 64'(out_rd), 64'd6);
    next_cycle_idle("addi_single_pulse");

    // SB at 0x1003 with three stall cycles
    dcache_req_ready = 1'b0;
    send(32'h00000023, 32'h0, 32'h00001003, 32'h000000AB, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("sb_req_valid_stall", 64'(dcache_req_valid), 64'd1);
    end
    check("sb_we", 64'(dcache_we), 64'h8);
    check("sb_din", 64'(dcache_din), 64'hAB000000);
    check("sb_addr", 64'(dcache_addr), 64'h1000);
    check("sb_re", 64'(dcache_re), 64'd0);
    @(negedge clk);
    check("sb_req_valid_grant", 64'(dcache_req_valid), 64'd1);
    dcache_req_ready = 1'b1;
    wait_valid(4, lat);
    dcache_req_ready = 1'b0;
    report("sb", lat);
    check("sb_lat", 64'(lat), 64'd5);
    check("sb_wb_en", 64'(out_wb_en), 64'd0);
    next_cycle_idle("sb_single_pulse");

    // SH at 0x1002, no stall
    dcache_req_ready = 1'b1;
    send(32'h00001023, 32'h0, 32'h00001002, 32'h0000BEEF, 32'h0);
    @(negedge clk);
    check("sh_we", 64'(dcache_we), 64'hC);
    check("sh_din", 64'(dcache_din), 64'hBEEF0000);
    wait_valid(1, lat);
    dcache_req_ready = 1'b0;
    report("sh", lat);
    check("sh_lat", 64'(lat), 64'd2);

    // LH x10 at 0x2002, response after two idle wait cycles
    dcache_req_ready = 1'b1;
    send(32'h00001503, 32'h0, 32'h00002002, 32'h0, 32'h0);
    @(negedge clk);
    check("lh_re", 64'(dcache_re), 64'd1);
    check("lh_we", 64'(dcache_we), 64'd0);
    check("lh_addr", 64'(dcache_addr), 64'h2000);
    @(negedge clk);
    dcache_req_ready = 1'b0;
    check("lh_req_dropped", 64'(dcache_req_valid), 64'd0);
    @(negedge clk);
    @(negedge clk);
    dcache_resp_valid = 1'b1; dcache_dout = 32'h8001ABCD;
    wait_valid(4, lat);
    dcache_resp_valid = 1'b0;
    report("lh", lat);
    check("lh_wb_data", 64'(out_wb_data), 64'hFFFF8001);
    check("lh_wb_en", 64'(out_wb_en), 64'd1);
    check("lh_rd", 64'(out_rd), 64'd10);

    // LW x11 misaligned at 0x3001
    send(32'h00002583, 32'h0, 32'h00003001, 32'h0, 32'h0);
    wait_valid(0, lat);
    report("lw_mis", lat);
    check("lwmis_lat", 64'(lat), 64'd1);
    check("lwmis_req_valid", 64'(dcache_req_valid), 64'd0);
    check("lwmis_misalign", 64'(out_misalign), 64'd1);
    check("lwmis_wb_en", 64'(out_wb_en), 64'd0);

    // LW with no response: times out after MAX_WAIT wait cycles
    dcache_req_ready = 1'b1;
    send(32'h00002583, 32'h0, 32'h00004000, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    dcache_req_ready = 1'b0;
    wait_valid(2, lat);
    report("lw_to", lat);
    check("lwto_lat", 64'(lat), 64'(MAX_WAIT + 2));
    check("lwto_timeout", 64'(out_timeout), 64'd1);
    check("lwto_wb_en", 64'(out_wb_en), 64'd0);
    send(32'h00000393, 32'h0, 32'h00000055, 32'h0, 32'h0);
    wait_valid(0, lat);
    report("addi", lat);
    check("after_to_timeout", 64'(out_timeout), 64'd0);
    check("after_to_wb_data", 64'(out_wb_data), 64'h55);

    // LBU x12 at 0x5001 with the response in the final wait cycle
    dcache_req_ready = 1'b1;
    send(32'h00004603, 32'h0, 32'h00005001, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    dcache_req_ready = 1'b0;
    repeat (3) @(negedge clk);
    dcache_resp_valid = 1'b1; dcache_dout = 32'h0000C300;
    wait_valid(5, lat);
    dcache_resp_valid = 1'b0;
    report("lbu", lat);
    check("lbu_lat", 64'(lat), 64'd6);
    check("lbu_timeout", 64'(out_timeout), 64'd0);
    check("lbu_wb_data", 64'(out_wb_data), 64'hC3);
    check("lbu_wb_en", 64'(out_wb_en), 64'd1);

    // JAL x1 with pc+4 wrapping past 2^32
    send(32'h000000EF, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h0);
    wait_valid(0, lat);
    report("jal", lat);
    check("jal_wb_data", 64'(out_wb_data), 64'h0);
    check("jal_wb_en", 64'(out_wb_en), 64'd1);

    // CSRRW x0, 0x51E <- 1
    send(32'h51E39073, 32'h0, 32'h0, 32'h0, 32'h00000001);
    wait_valid(0, lat);
    report("csrrw0", lat);
    check("csr0_wb_en", 64'(out_wb_en), 64'd0);
    @(negedge clk);
    check("csr0_value", csr_out, 64'h00000000_00000001);

    // CSRRW x5, 0x51E <- 0xDEAD; returns prior 1
    send(32'h51E392F3, 32'h0, 32'h0, 32'h0, 32'h0000DEAD);
    wait_valid(0, lat);
    report("csrrw", lat);
    check("csrrw_wb_data", 64'(out_wb_data), 64'h1);
    check("csrrw_wb_en", 64'(out_wb_en), 64'd1);
    check("csrrw_in_done", 64'(csr_out[31:0]), 64'h1);
    @(negedge clk);
    check("csrrw_after", 64'(csr_out[31:0]), 64'hDEAD);

    // CSRRWI x5, 0x51F <- zimm 0x15
    send(32'h51FAD2F3, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF);
    wait_valid(0, lat);
    report("csrrwi", lat);
    check("csrrwi_wb_data", 64'(out_wb_data), 64'h0);
    @(negedge clk);
    check("csrrwi_after", csr_out, 64'h00000015_0000DEAD);

    // CSRRW to 0x520 is outside the bank: no write, returns 0
    send(32'h520392F3, 32'h0, 32'h0, 32'h0, 32'h00001234);
    wait_valid(0, lat);
    report("csr_oor", lat);
    check("csroor_wb_data", 64'(out_wb_data), 64'h0);
    @(negedge clk);
    check("csroor_csr", csr_out, 64'h00000015_0000DEAD);

    send(32'h00000413, 32'h0, 32'hCAFE0000, 32'h0, 32'h0);
    wait_valid(0, lat);
    report("addi", lat);
    check("addi8_wb_data", 64'(out_wb_data), 64'hCAFE0000);

    // Reset asserted while a load sits in WAIT
    dcache_req_ready = 1'b1;
    send(32'h00002583, 32'h0, 32'h00006000, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    dcache_req_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rstw_out_valid", 64'(out_valid), 64'd0);
    check("rstw_req_valid", 64'(dcache_req_valid), 64'd0);
    check("rstw_re", 64'(dcache_re), 64'd0);
    check("rstw_addr", 64'(dcache_addr), 64'd0);
    check("rstw_rd", 64'(out_rd), 64'd0);
    check("rstw_wb_data", 64'(out_wb_data), 64'd0);
    check("rstw_csr", csr_out, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    dcache_resp_valid = 1'b1; dcache_dout = 32'h12345678;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dcache_resp_valid = 1'b0;
      if (out_valid) seen++;
    end
    $display("txn late_rsp out_valid_pulses=%0d", seen);
    check("late_resp_ignored", 64'(seen), 64'd0);

    send(32'h00000313, 32'h0, 32'h00000077, 32'h0, 32'h0);
    wait_valid(0, lat);
    report("addi", lat);
    check("post_rst_wb_data", 64'(out_wb_data), 64'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
